pipe_branch_predictor: RTL and testbench
========================================

Name: pipe_branch_predictor

Overview:
- Parametrised branch target buffer with 2-bit saturating direction counters, used in the IF stage of the 5-stage pipeline.
- IF looks up the current PC combinationally and gets a predicted next PC.
- ID resolves the branch or jump one cycle later and drives the update port. The block reports mispredict and the redirect PC, which lets the pipeline flush only on a wrong prediction rather than on every taken branch.
- Holds saturating branch and mispredict statistic counters for the LED debug mux.

Parameters:
- PC_W, 8, width of PC and target addresses (byte address, word aligned).
- ENTRIES, 16, number of BTB entries; power of 2, minimum 2. IDX_W = log2(ENTRIES). Requires IDX_W+2 < PC_W.
- CNT_W, 16, width of statistic counters.

Ports:
- SYS_clk  in  1  sole clock; all state changes on the rising edge.
- SYS_reset  in  1  synchronous, active-high reset.
- bp_clear  in  1  synchronous invalidate-all of BTB entries; statistic counters are kept.
- lookup_pc  in  PC_W  current IF PC.
- pred_taken  out  1  prediction for lookup_pc (combinational).
- pred_target  out  PC_W  predicted next PC (combinational).
- upd_valid  in  1  ID stage holds a resolved branch/jump this cycle.
- upd_pc  in  PC_W  PC of the resolved instruction.
- upd_is_jump  in  1  instruction is an unconditional jump.
- upd_taken  in  1  actual outcome.
- upd_target  in  PC_W  actual target when taken.
- upd_pred_taken  in  1  prediction made in IF, carried through IF/ID.
- upd_pred_target  in  PC_W  predicted target, carried through IF/ID.
- mispredict  out  1  combinational; pipeline flushes IF/ID when high.
- redirect_pc  out  PC_W  correct next PC (combinational).
- branch_cnt  out  CNT_W  number of accepted updates.
- mispredict_cnt  out  CNT_W  number of mispredicts.

Behaviour:
- Address split: index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]. Bits pc[1:0] are ignored.
- Entry fields: valid, tag, target[PC_W], ctr[2], is_jump.
- Lookup (combinational): hit = valid AND tag match.
  - pred_taken = hit AND (is_jump OR ctr[1]).
  - pred_target = entry target when pred_taken, else lookup_pc+4 (mod 2^PC_W; wraps 8'hFC to 8'h00).
- mispredict = upd_valid AND ((upd_taken != upd_pred_taken) OR (upd_taken AND upd_target != upd_pred_target)).
- redirect_pc = upd_taken ? upd_target : upd_pc+4. Its value is meaningless when mispredict=0.
- Update (registered, visible from the next cycle), only when upd_valid=1:
  - Tag hit at index: ctr increments when taken and decrements when not, saturating at 3 and 0. When taken, target<=upd_target and is_jump<=upd_is_jump.
  - Miss and taken: allocate/replace the entry: valid=1, tag, target, is_jump, ctr=2'b10 (weakly taken).
  - Miss and not taken: no change to the entry.
- Statistic counters, on upd_valid: branch_cnt+1 and, if mispredict, mispredict_cnt+1. Both saturate at all-ones; no wrap.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents (no bypass).
- Reset: SYS_reset=1 clears all valid bits, ctrs to 0 and both counters to 0; upd_valid is ignored in that cycle.
  - Outputs after reset: pred_taken=0, pred_target=lookup_pc+4, counters 0.
  - Reset mid-stream drops any pending update.
- bp_clear: clears all valid bits; same priority as reset over updates for the entries; statistic counters still update in that cycle.
- Precedence: SYS_reset > bp_clear > update.

Test Plan:
- Reset, lookup_pc=8'h10 -> pred_taken=0, pred_target=8'h14, branch_cnt=0, mispredict_cnt=0.
- Update pc=8'h10, taken=1, target=8'h40, pred_taken=0 -> same cycle: mispredict=1, redirect_pc=8'h40. Next cycle: lookup 8'h10 gives pred_taken=1, pred_target=8'h40, branch_cnt=1, mispredict_cnt=1.
- Two not-taken updates at 8'h10 (ctr 10 to 01 to 00) -> after the first, pred_taken=0 and pred_target=8'h14. A subsequent taken update gives ctr=01, still predicted not taken.
- Aliasing at default params: 8'h50 and 8'h10 share index 4, with tags 1 and 0 -> lookup 8'h50 misses. Taken update of 8'h50 to 8'h80 replaces the entry; lookup 8'h10 then misses and lookup 8'h50 predicts 8'h80.
- Jump entry at 8'hFC to 8'h00 with is_jump=1 -> always predicted taken regardless of ctr. A non-hit lookup at 8'hFC returns pred_target=8'h00 (wrap).
- Update at index 4 with concurrent lookup of the same PC returns old data. SYS_reset high with upd_valid=1 leaves no entry written. CNT_W=2 with 5 mispredicts gives mispredict_cnt=3. bp_clear leaves branch_cnt intact and invalidates all entries.

Source files
------------

// File: rtl/pipe_branch_predictor.sv
// rtl/pipe_branch_predictor.sv - IF-stage branch target buffer with 2-bit direction counters
// Lookup is combinational; ID-stage resolution updates the table and reports mispredicts.
module pipe_branch_predictor #(
  parameter int PC_W    = 8,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             SYS_clk,
  input  logic             SYS_reset,
  input  logic             bp_clear,
  input  logic [PC_W-1:0]  lookup_pc,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_is_jump,
  input  logic             upd_taken,
  input  logic [PC_W-1:0]  upd_target,
  input  logic             upd_pred_taken,
  input  logic [PC_W-1:0]  upd_pred_target,
  output logic             mispredict,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic             jump_q   [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit;

  assign lk_idx  = lookup_pc[IDX_W+1:2];
  assign lk_tag  = lookup_pc[PC_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[PC_W-1:IDX_W+2];

  assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Jumps are always taken; conditional branches follow the counter MSB.
  assign pred_taken  = lk_hit && (jump_q[lk_idx] || ctr_q[lk_idx][1]);
  assign pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + PC_W'(4);

  assign mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                     (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + PC_W'(4);

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b00;
      end
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (upd_valid) begin
        if (branch_cnt != '1)
          branch_cnt <= branch_cnt + CNT_W'(1);
        if (mispredict && (mispredict_cnt != '1))
          mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end
      // A clear wins over the table write but not over the statistics above.
      if (bp_clear) begin
        for (int i = 0; i < ENTRIES; i++)
          valid_q[i] <= 1'b0;
      end else if (upd_valid) begin
        if (upd_hit) begin
          if (upd_taken) begin
            if (ctr_q[upd_idx] != 2'b11)
              ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
            target_q[upd_idx] <= upd_target;
            jump_q[upd_idx]   <= upd_is_jump;
          end else if (ctr_q[upd_idx] != 2'b00) begin
            ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
          end
        end else if (upd_taken) begin
          valid_q[upd_idx]  <= 1'b1;
          tag_q[upd_idx]    <= upd_tag;
          target_q[upd_idx] <= upd_target;
          jump_q[upd_idx]   <= upd_is_jump;
          ctr_q[upd_idx]    <= 2'b10;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_branch_predictor.sv
// tb/tb_pipe_branch_predictor.sv - directed and random checks of pipe_branch_predictor
// A second instance with 2-bit statistic counters exercises counter saturation.
module tb_pipe_branch_predictor;

  localparam int E = 16;

  logic       clk = 1'b0;
  logic       rst, clr, uv, ujmp, utk, uptk;
  logic [7:0] lpc, upc, utgt, uptgt;

  logic        pt, pt2, mp, mp2;
  logic [7:0]  ptg, ptg2, rd, rd2;
  logic [15:0] bc, mc;
  logic [1:0]  bc2, mc2;

  always #5 clk = ~clk;

  pipe_branch_predictor u_dut (
    .SYS_clk(clk), .SYS_reset(rst), .bp_clear(clr), .lookup_pc(lpc),
    .pred_taken(pt), .pred_target(ptg), .upd_valid(uv), .upd_pc(upc),
    .upd_is_jump(ujmp), .upd_taken(utk), .upd_target(utgt),
    .upd_pred_taken(uptk), .upd_pred_target(uptgt), .mispredict(mp),
    .redirect_pc(rd), .branch_cnt(bc), .mispredict_cnt(mc)
  );

  pipe_branch_predictor #(.CNT_W(2)) u_small (
    .SYS_clk(clk), .SYS_reset(rst), .bp_clear(clr), .lookup_pc(lpc),
    .pred_taken(pt2), .pred_target(ptg2), .upd_valid(uv), .upd_pc(upc),
    .upd_is_jump(ujmp), .upd_taken(utk), .upd_target(utgt),
    .upd_pred_taken(uptk), .upd_pred_target(uptgt), .mispredict(mp2),
    .redirect_pc(rd2), .branch_cnt(bc2), .mispredict_cnt(mc2)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one record per table slot, addressed by word number.
  int m_valid [E];
  int m_tag   [E];
  int m_tgt   [E];
  int m_ctr   [E];
  int m_jmp   [E];
  int m_bc, m_mc, m_bc2, m_mc2;

  function automatic int slot(int pc);
    return (pc / 4) % E;
  endfunction

  function automatic int m_hit(int pc);
    return (m_valid[slot(pc)] != 0 && m_tag[slot(pc)] == pc / (4 * E)) ? 1 : 0;
  endfunction

  function automatic int m_ptaken(int pc);
    return (m_hit(pc) != 0 && (m_jmp[slot(pc)] != 0 || m_ctr[slot(pc)] >= 2)) ? 1 : 0;
  endfunction

  function automatic int m_ptarget(int pc);
    return (m_ptaken(pc) != 0) ? m_tgt[slot(pc)] : (pc + 4) % 256;
  endfunction

  function automatic int m_misp();
    if (!uv) return 0;
    return (utk != uptk || (utk && utgt != uptgt)) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int i, mis;
    i   = slot(int'(upc));
    mis = m_misp();
    if (rst) begin
      for (int k = 0; k < E; k++) begin m_valid[k] = 0; m_ctr[k] = 0; end
      m_bc = 0; m_mc = 0; m_bc2 = 0; m_mc2 = 0;
      return;
    end
    if (uv) begin
      m_bc  = (m_bc  < 65535) ? m_bc + 1 : m_bc;
      m_bc2 = (m_bc2 < 3)     ? m_bc2 + 1 : m_bc2;
      if (mis != 0) begin
        m_mc  = (m_mc  < 65535) ? m_mc + 1 : m_mc;
        m_mc2 = (m_mc2 < 3)     ? m_mc2 + 1 : m_mc2;
      end
    end
    if (clr) begin
      for (int k = 0; k < E; k++) m_valid[k] = 0;
    end else if (uv) begin
      if (m_hit(int'(upc)) != 0) begin
        if (utk) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = int'(utgt);
          m_jmp[i] = int'(ujmp);
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (utk) begin
        m_valid[i] = 1; m_tag[i] = int'(upc) / (4 * E);
        m_tgt[i] = int'(utgt); m_jmp[i] = int'(ujmp); m_ctr[i] = 2;
      end
    end
  endtask

  // Inputs are already driven; check combinational and registered outputs, then clock.
  task automatic step();
    #2;
    chk("pred_taken",  int'(pt),  m_ptaken(int'(lpc)));
    chk("pred_target", int'(ptg), m_ptarget(int'(lpc)));
    chk("mispredict",  int'(mp),  m_misp());
    if (m_misp() != 0)
      chk("redirect_pc", int'(rd), utk ? int'(utgt) : (int'(upc) + 4) % 256);
    chk("branch_cnt",     int'(bc),  m_bc);
    chk("mispredict_cnt", int'(mc),  m_mc);
    chk("branch_cnt_w2",  int'(bc2), m_bc2);
    chk("mispredict_cnt_w2", int'(mc2), m_mc2);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input logic [7:0] pc);
    uv = 1'b0; rst = 1'b0; clr = 1'b0; lpc = pc;
    upc = 8'h00; ujmp = 1'b0; utk = 1'b0; utgt = 8'h00; uptk = 1'b0; uptgt = 8'h00;
  endtask

  // Update carrying the prediction the model says IF would have made for pc.
  task automatic upd(input logic [7:0] pc, input logic tk, input logic [7:0] tg,
                     input logic jmp);
    uv = 1'b1; upc = pc; utk = tk; utgt = tg; ujmp = jmp;
    uptk  = (m_ptaken(int'(pc)) != 0);
    uptgt = 8'(m_ptarget(int'(pc)));
  endtask

  initial begin
    for (int k = 0; k < E; k++) begin
      m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_ctr[k] = 0; m_jmp[k] = 0;
    end
    m_bc = 0; m_mc = 0; m_bc2 = 0; m_mc2 = 0;
    idle(8'h10);
    @(posedge clk); #1;

    // Reset with a concurrent update must leave the table empty.
    rst = 1'b1; uv = 1'b1; upc = 8'h10; utk = 1'b1; utgt = 8'h40;
    @(posedge clk); model_edge(); #1;
    idle(8'h10);
    #2;
    chk("reset_pred_taken",  int'(pt),  0);
    chk("reset_pred_target", int'(ptg), 8'h14);
    chk("reset_branch_cnt",  int'(bc),  0);
    step();

    // First taken branch: mispredicts, allocates; same-cycle lookup sees old data.
    upd(8'h10, 1'b1, 8'h40, 1'b0);
    #2;
    chk("first_mispredict", int'(mp), 1);
    chk("first_redirect",   int'(rd), 8'h40);
    chk("same_cycle_old",   int'(pt), 0);
    step();
    idle(8'h10);
    #2;
    chk("alloc_target", int'(ptg), 8'h40);
    chk("alloc_mcnt",   int'(mc),  1);
    step();

    // Counter walks 10 -> 01 -> 00, then a taken update only reaches 01.
    upd(8'h10, 1'b0, 8'h00, 1'b0); step();
    upd(8'h10, 1'b0, 8'h00, 1'b0); step();
    upd(8'h10, 1'b1, 8'h40, 1'b0); step();
    idle(8'h10); step();

    // Aliasing: 0x50 shares slot 4 with 0x10 under a different tag.
    idle(8'h50); step();
    upd(8'h50, 1'b1, 8'h80, 1'b0); step();
    idle(8'h10); step();
    idle(8'h50);
    #2;
    chk("alias_target", int'(ptg), 8'h80);
    step();

    // Wrap of the fall-through PC and a jump entry that ignores its counter.
    idle(8'hFC);
    #2;
    chk("wrap_target", int'(ptg), 8'h00);
    step();
    upd(8'hFC, 1'b1, 8'h00, 1'b1); step();
    for (int n = 0; n < 3; n++) begin
      upd(8'hFC, 1'b0, 8'h00, 1'b0); lpc = 8'hFC; step();
    end
    idle(8'hFC); step();

    // Clear with a concurrent update: counters still advance, entries vanish.
    upd(8'h50, 1'b1, 8'h90, 1'b0); clr = 1'b1; step();
    idle(8'h50); step();
    idle(8'hFC); step();

    // Random traffic over a small PC pool so hits, aliases and saturation all occur.
    for (int n = 0; n < 600; n++) begin
      logic [7:0] a;
      idle(8'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) |
              $urandom_range(0, 3)));
      a = 8'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
      if ($urandom_range(0, 2) != 0) begin
        upd(a, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 63) << 2),
            1'($urandom_range(0, 3) == 0));
        if ($urandom_range(0, 4) == 0) begin
          uptk = 1'($urandom_range(0, 1)); uptgt = 8'($urandom);
        end
      end
      clr = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 127) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
